// File: rtl/pixel_stream_processor.sv
// pixel_stream_processor: gathers 3 packed-RGB bus words, processes whole pixels in one cycle, drains with backpressure.
// Define LUMA_THRESH_EN to threshold on weighted luma instead of the plain channel average.
module pixel_stream_processor #(
  parameter int DATA_WIDTH = 32,
  parameter int COLOR_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [1:0]            mode,
  input  logic [7:0]            proc_val,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic                  done
);
  localparam int NPIX = DATA_WIDTH / 8;
  if (COLOR_SIZE != 8) begin : g_bad_color
    $error("COLOR_SIZE must be 8");
  end
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] grp_q [3];
  logic [DATA_WIDTH-1:0] proc_w [3];
  logic [3*DATA_WIDTH-1:0] flat, proc_flat;
  logic [1:0] wcnt_q, rcnt_q, mode_q;
  logic [7:0] val_q;
  logic last_q, acc, fin;
  logic [31:0] npix;
  assign in_rdy = state_q == FILL;
  assign acc = in_vld && in_rdy;
  assign fin = state_q == DRAIN && out_rdy && rcnt_q == wcnt_q - 2'd1;
  assign flat = {grp_q[2], grp_q[1], grp_q[0]};
  assign npix = 32'(wcnt_q) * DATA_WIDTH / 24;
  assign proc_w[0] = proc_flat[DATA_WIDTH-1:0];
  assign proc_w[1] = proc_flat[2*DATA_WIDTH-1:DATA_WIDTH];
  assign proc_w[2] = proc_flat[3*DATA_WIDTH-1:2*DATA_WIDTH];
  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    logic [23:0] px, res;
    logic [7:0] m;
    logic [8:0] sb, sg, sr;
    assign px = flat[24*p +: 24];
`ifdef LUMA_THRESH_EN
    logic [15:0] luma;
    assign luma = 16'd29 * px[7:0] + 16'd150 * px[15:8] + 16'd77 * px[23:16];
    assign m = 8'(luma >> 8);
`else
    logic [9:0] sum;
    assign sum = {2'b0, px[7:0]} + {2'b0, px[15:8]} + {2'b0, px[23:16]};
    assign m = 8'(sum / 10'd3);
`endif
    assign sb = {1'b0, px[7:0]} + {1'b0, val_q};
    assign sg = {1'b0, px[15:8]} + {1'b0, val_q};
    assign sr = {1'b0, px[23:16]} + {1'b0, val_q};
    assign res = mode_q == 2'd0 ? px
               : mode_q == 2'd1 ? {24{m > val_q}}
               : mode_q == 2'd2 ? {sr[8] ? 8'hFF : sr[7:0], sg[8] ? 8'hFF : sg[7:0], sb[8] ? 8'hFF : sb[7:0]}
               : ~px;
    // pixels not wholly inside the filled words (trailing partial pixel, unfilled slots) pass through
    assign proc_flat[24*p +: 24] = 32'(p) < npix ? res : px;
  end
  always_comb begin
    state_d = state_q;
    state_d = state_q == FILL ? ((acc && (wcnt_q == 2'd2 || in_last)) ? CALC : FILL)
            : state_q == CALC ? DRAIN
            : fin ? FILL : DRAIN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q <= '{default: '0};
      wcnt_q <= '0;
      rcnt_q <= '0;
      mode_q <= '0;
      val_q <= '0;
      last_q <= 1'b0;
      out_data <= '0;
      out_vld <= 1'b0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= fin && out_last;
      if (acc) begin
        grp_q[wcnt_q] <= in_data;
        wcnt_q <= wcnt_q + 2'd1;
        last_q <= in_last;
        if (wcnt_q == 2'd0) begin
          mode_q <= mode;
          val_q <= proc_val;
        end
      end
      if (state_q == CALC) begin
        grp_q <= proc_w;
        out_data <= proc_w[0];
        out_vld <= 1'b1;
        out_last <= last_q && wcnt_q == 2'd1;
      end
      if (state_q == DRAIN && out_rdy) begin
        rcnt_q <= fin ? 2'd0 : rcnt_q + 2'd1;
        wcnt_q <= fin ? 2'd0 : wcnt_q;
        out_vld <= !fin;
        out_data <= fin ? out_data : grp_q[rcnt_q + 2'd1];
        out_last <= !fin && last_q && rcnt_q + 2'd2 == wcnt_q;
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_processor.sv
// tb_pixel_stream_processor: drives a 32-bit and a 64-bit instance in lockstep and checks both against a byte-level model.
module tb_pixel_stream_processor;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic in_vld = 0, in_last = 0, out_rdy = 0;
  logic [63:0] in_data = '0;
  logic [1:0] mode = '0;
  logic [7:0] proc_val = '0;
  logic in_rdy32, in_rdy64, out_vld32, out_vld64, out_last32, out_last64, done32, done64;
  logic [31:0] out_data32;
  logic [63:0] out_data64;
  int checks = 0, errors = 0;
  logic [63:0] wq [3];
  logic [63:0] got32 [3], got64 [3];

  pixel_stream_processor #(.DATA_WIDTH(32), .COLOR_SIZE(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy32), .in_data(in_data[31:0]),
    .in_last(in_last), .mode(mode), .proc_val(proc_val), .out_data(out_data32), .out_vld(out_vld32),
    .out_rdy(out_rdy), .out_last(out_last32), .done(done32));
  pixel_stream_processor #(.DATA_WIDTH(64), .COLOR_SIZE(8)) u64 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy64), .in_data(in_data),
    .in_last(in_last), .mode(mode), .proc_val(proc_val), .out_data(out_data64), .out_vld(out_vld64),
    .out_rdy(out_rdy), .out_last(out_last64), .done(done64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // group as a flat byte list; first floor(bytes/3) pixels get the mode function
  function automatic logic [63:0] model(input int dw, input int n, input int idx, input logic [1:0] md, input logic [7:0] v);
    logic [7:0] b [24];
    int bpw, m, c;
    logic [63:0] r;
    bpw = dw / 8;
    for (int i = 0; i < 24; i++) b[i] = 8'h00;
    for (int i = 0; i < n * bpw; i++) b[i] = wq[i / bpw][8 * (i % bpw) +: 8];
    for (int k = 0; k < n * bpw / 3; k++) begin
`ifdef LUMA_THRESH_EN
      m = (29 * int'(b[3*k]) + 150 * int'(b[3*k+1]) + 77 * int'(b[3*k+2])) / 256;
`else
      m = (int'(b[3*k]) + int'(b[3*k+1]) + int'(b[3*k+2])) / 3;
`endif
      for (int j = 0; j < 3; j++) begin
        c = int'(b[3*k+j]);
        c = md == 2'd1 ? (m > int'(v) ? 255 : 0)
          : md == 2'd2 ? (c + int'(v) > 255 ? 255 : c + int'(v))
          : md == 2'd3 ? 255 - c : c;
        b[3*k+j] = 8'(c);
      end
    end
    r = '0;
    for (int j = 0; j < bpw; j++) r[8*j +: 8] = b[idx * bpw + j];
    return r;
  endfunction

  task automatic send(input int n, input bit last, input logic [1:0] md, input logic [7:0] v, input bit flip);
    for (int i = 0; i < n; i++) begin
      in_data = wq[i];
      in_vld = 1;
      in_last = last && i == n - 1;
      mode = (flip && i > 0) ? 2'd0 : md;
      proc_val = (flip && i > 0) ? ~v : v;
      chk("in_rdy_fill", {62'b0, in_rdy64, in_rdy32}, 64'h3);
      @(negedge clk);
    end
    in_vld = 0;
    in_last = 0;
  endtask

  task automatic recv(input int n, input bit last, input logic [1:0] md, input logic [7:0] v, input bit bp);
    int i = 0, cyc = 0;
    logic [63:0] e;
    chk("calc_no_vld", {62'b0, out_vld64, out_vld32}, 64'h0);
    @(negedge clk);
    while (i < n && cyc < 40) begin
      out_rdy = bp ? (cyc % 3 == 0) : 1'b1;
      chk("out_vld", {62'b0, out_vld64, out_vld32}, 64'h3);
      chk("in_rdy_drain", {62'b0, in_rdy64, in_rdy32}, 64'h0);
      e = model(32, n, i, md, v);
      chk("data32", {32'b0, out_data32}, {32'b0, e[31:0]});
      chk("data64", out_data64, model(64, n, i, md, v));
      chk("out_last", {62'b0, out_last64, out_last32}, (last && i == n - 1) ? 64'h3 : 64'h0);
      got32[i] = {32'b0, out_data32};
      got64[i] = out_data64;
      @(negedge clk);
      if (out_rdy) i++;
      cyc++;
    end
    if (i < n) chk("drain_timeout", i, n);
    out_rdy = 0;
    chk("done", {62'b0, done64, done32}, last ? 64'h3 : 64'h0);
    chk("idle", {60'b0, out_vld64, out_vld32, in_rdy64, in_rdy32}, 64'h3);
    @(negedge clk);
    chk("done_clear", {62'b0, done64, done32}, 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] md;
    logic [7:0] v;
    int n;
    bit last, bp;
    repeat (2) @(negedge clk);
    chk("rst_outs", {out_vld64, out_vld32, out_last64, out_last32, done64, done32}, 64'h0);
    chk("rst_data", {out_data64 | {32'b0, out_data32}}, 64'h0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_rdy", {62'b0, in_rdy64, in_rdy32}, 64'h3);
    // threshold at 0x80 on 0x818181, 0x7F7F7F, 0xFFFFFF, 0x000000
    wq[0] = 64'h7F818181; wq[1] = 64'hFFFF7F7F; wq[2] = 64'h000000FF;
    send(3, 0, 2'd1, 8'h80, 0);
    recv(3, 0, 2'd1, 8'h80, 0);
    chk("thr_w0", got32[0], 64'h00FFFFFF);
    chk("thr_w1", got32[1], 64'hFFFF0000);
    chk("thr_w2", got32[2], 64'h000000FF);
    // brightness saturation
    for (int i = 0; i < 3; i++) wq[i] = {8{8'hF0}};
    send(3, 1, 2'd2, 8'h20, 0);
    recv(3, 1, 2'd2, 8'h20, 0);
    for (int i = 0; i < 3; i++) chk("bright_sat64", got64[i], {8{8'hFF}});
    // single-word invert with trailing partial pixel
    wq[0] = 64'hA5A5A5A5_11223344;
    send(1, 1, 2'd3, 8'h00, 0);
    recv(1, 1, 2'd3, 8'h00, 0);
    chk("inv_partial", got32[0], 64'h11DDCCBB);
    // backpressure
    for (int i = 0; i < 3; i++) wq[i] = {$urandom, $urandom};
    v = 8'($urandom);
    send(3, 1, 2'd2, v, 0);
    recv(3, 1, 2'd2, v, 1);
    // mode changed after first word: latched threshold, then bypass group
    for (int i = 0; i < 3; i++) wq[i] = {$urandom, $urandom};
    v = 8'($urandom_range(60, 200));
    send(3, 0, 2'd1, v, 1);
    recv(3, 0, 2'd1, v, 0);
    for (int i = 0; i < 3; i++) wq[i] = {$urandom, $urandom};
    send(3, 0, 2'd0, v, 0);
    recv(3, 0, 2'd0, v, 0);
    for (int i = 0; i < 3; i++) chk("bypass", got64[i], wq[i]);
    // reset during DRAIN
    for (int i = 0; i < 3; i++) wq[i] = {$urandom, $urandom};
    send(3, 1, 2'd3, 8'h00, 0);
    @(negedge clk);
    out_rdy = 1;
    @(negedge clk);
    out_rdy = 0;
    chk("pre_rst_vld", {62'b0, out_vld64, out_vld32}, 64'h3);
    rst_n = 0;
    #1;
    chk("mid_rst_outs", {out_vld64, out_vld32, out_last64, out_last32, done64, done32}, 64'h0);
    chk("mid_rst_data", out_data64 | {32'b0, out_data32}, 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_rdy", {62'b0, in_rdy64, in_rdy32}, 64'h3);
    for (int i = 0; i < 3; i++) wq[i] = {$urandom, $urandom};
    v = 8'($urandom);
    send(2, 1, 2'd1, v, 0);
    recv(2, 1, 2'd1, v, 0);
    // randomized groups
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 3);
      last = n < 3 ? 1'b1 : 1'($urandom);
      md = 2'($urandom);
      v = 8'($urandom);
      bp = 1'($urandom);
      for (int i = 0; i < 3; i++) wq[i] = {$urandom, $urandom};
      send(n, last, md, v, 0);
      recv(n, last, md, v, bp);
    end
`ifdef LUMA_THRESH_EN
    wq[0] = 64'h00FF0000;
    send(1, 1, 2'd1, 8'd75, 0);
    recv(1, 1, 2'd1, 8'd75, 0);
    chk("luma_above", {40'b0, got32[0][23:0]}, 64'hFFFFFF);
    send(1, 1, 2'd1, 8'd76, 0);
    recv(1, 1, 2'd1, 8'd76, 0);
    chk("luma_equal", {40'b0, got32[0][23:0]}, 64'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
